// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST sequencer / MISR compactor.
// Holds the FSM state encoding, default MISR constants and the MISR step function.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [7:0] MISR_POLY_DEF  = 8'h1D;
  localparam logic [7:0] GOLDEN_SIG_DEF = 8'hCD;

  // One MISR step on a w-bit register (w <= 32): shift left, fold taps on MSB, xor response.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] resp,
                                            input logic [31:0] poly,
                                            input int unsigned w);
    logic [31:0] mask;
    logic [31:0] nxt;
    logic [4:0]  msb_idx;
    mask    = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    msb_idx = 5'(w - 1);
    nxt     = (sig << 1) ^ (sig[msb_idx] ? poly : 32'd0) ^ resp;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Signature register for the BIST compactor: synchronous clear, folds one
// response per enabled cycle; also exposes the next value for pass evaluation.
module bist_misr
  import bist_pkg::*;
#(
  parameter int                 MISR_W    = 8,
  parameter int                 RESP_W    = 3,
  parameter logic [MISR_W-1:0]  MISR_POLY = MISR_W'(MISR_POLY_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [RESP_W-1:0] i_resp,
  output logic [MISR_W-1:0] o_sig,
  output logic [MISR_W-1:0] o_sig_next
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_next;

  assign w_next = MISR_W'(misr_step(32'(r_sig), 32'(i_resp), 32'(MISR_POLY), MISR_W));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig      = r_sig;
  assign o_sig_next = w_next;

endmodule

// File: rtl/bist_seq_misr.sv
// BIST sequencer: applies exhaustive counter patterns to a CUT and compacts
// responses in a MISR. Optional per-output ones counters via BIST_RESP_CNT_EN.
module bist_seq_misr
  import bist_pkg::*;
#(
  parameter int                PAT_W      = 3,
  parameter int                RESP_W     = 3,
  parameter int                NUM_PAT    = 8,
  parameter int                SETTLE     = 2,
  parameter int                MISR_W     = 8,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(MISR_POLY_DEF),
  parameter logic [MISR_W-1:0] GOLDEN_SIG = MISR_W'(GOLDEN_SIG_DEF),
  localparam int               CW         = $clog2(NUM_PAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PAT_W-1:0]  pat_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] sig_o
`ifdef BIST_RESP_CNT_EN
  ,
  output logic [RESP_W*CW-1:0] ones_cnt_o
`endif
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            r_state;
  logic [PAT_W-1:0]  r_pat;
  logic [SW-1:0]     r_settle;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              w_seed;
  logic              w_cap;
  logic [MISR_W-1:0] w_sig_next;

  // start is a one-cycle request, acted on only from IDLE or DONE; no queueing.
  assign w_seed = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_cap  = (r_state == ST_CAPTURE);

  bist_misr #(
    .MISR_W    (MISR_W),
    .RESP_W    (RESP_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_seed),
    .i_en       (w_cap),
    .i_resp     (resp_i),
    .o_sig      (sig_o),
    .o_sig_next (w_sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pat    <= '0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_APPLY;
            r_pat    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_state  <= ST_CAPTURE;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // Pass is judged on the signature being written this same edge.
          if (r_pat == PAT_W'(NUM_PAT - 1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_sig_next == GOLDEN_SIG);
          end else begin
            r_state <= ST_APPLY;
            r_pat   <= r_pat + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pat_o = r_pat;
  assign busy  = r_busy;
  assign done  = r_done;
  assign pass  = r_pass;

`ifdef BIST_RESP_CNT_EN
  logic [CW-1:0] r_cnt [RESP_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < RESP_W; i++) begin
      if (rst || w_seed) begin
        r_cnt[i] <= '0;
      end else if (w_cap) begin
        r_cnt[i] <= r_cnt[i] + CW'(resp_i[i]);
      end
    end
  end

  for (genvar g = 0; g < RESP_W; g++) begin : g_cnt_out
    assign ones_cnt_o[g*CW +: CW] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_bist_seq_misr.sv
// Self-checking bench for bist_seq_misr: default, NUM_PAT=1 and SETTLE=1 instances.
// Optional ones counters are checked when BIST_RESP_CNT_EN is defined.
module tb_bist_seq_misr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // Book CUT responses (XYZ) per pattern, optionally with node s stuck-at-1.
  function automatic logic [2:0] cut_resp(input logic [2:0] p, input bit fault);
    if (fault) return (p == 3'd6) ? 3'd3 : (p == 3'd7) ? 3'd2 : 3'd7;
    return (p < 3'd6) ? 3'd7 : 3'd1;
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] s, input logic [2:0] r);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {5'b0, r};
  endfunction

  function automatic logic [7:0] model_sig(input bit fault);
    logic [7:0] s;
    s = 8'h00;
    for (int p = 0; p < 8; p++) s = fold(s, cut_resp(3'(p), fault));
    return s;
  endfunction

  // dut0: default parameters
  logic       start0 = 1'b0;
  bit         fault0 = 1'b0;
  logic [2:0] pat0, resp0;
  logic       busy0, done0, pass0;
  logic [7:0] sig0;
  assign resp0 = cut_resp(pat0, fault0);

  // dut1: NUM_PAT=1
  logic       start1 = 1'b0;
  logic [2:0] pat1;
  logic [2:0] resp1 = 3'b101;
  logic       busy1, done1, pass1;
  logic [7:0] sig1;

  // dut2: SETTLE=1
  logic       start2 = 1'b0;
  logic [2:0] pat2;
  logic [2:0] resp2 = 3'b000;
  logic       busy2, done2, pass2;
  logic [7:0] sig2;

`ifdef BIST_RESP_CNT_EN
  logic [11:0] ones0;
  logic [2:0]  ones1;
  logic [11:0] ones2;
`endif

  bist_seq_misr u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pat_o(pat0), .resp_i(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .sig_o(sig0)
`ifdef BIST_RESP_CNT_EN
    , .ones_cnt_o(ones0)
`endif
  );

  bist_seq_misr #(.NUM_PAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .pat_o(pat1), .resp_i(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .sig_o(sig1)
`ifdef BIST_RESP_CNT_EN
    , .ones_cnt_o(ones1)
`endif
  );

  bist_seq_misr #(.SETTLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .pat_o(pat2), .resp_i(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .sig_o(sig2)
`ifdef BIST_RESP_CNT_EN
    , .ones_cnt_o(ones2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_pat"},  32'(pat0),  32'd0);
    chk({tag, "_sig"},  32'(sig0),  32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_pass"}, 32'(pass0), 32'd0);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  // Entered #1 after the edge that sampled start (edge 0); runs dut0 to DONE.
  task automatic run0(input bit poke, input string tag);
    int         k;
    bit         pat_ok;
    logic [7:0] exp;
    k      = 0;
    pat_ok = 1'b1;
    while (!done0 && k < 200) begin
      if (k < 24 && (pat0 !== 3'(k / 3) || busy0 !== 1'b1)) pat_ok = 1'b0;
      start0 = poke && (k == 1 || k == 2 || k == 8);
      tick();
      k++;
    end
    start0 = 1'b0;
    chk({tag, "_latency"}, 32'(k + 1), 32'd25);
    chk({tag, "_pat_seq"}, 32'(pat_ok), 32'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk({tag, "_sig"},  32'(sig0),  32'(exp));
      chk({tag, "_pass"}, 32'(pass0), 32'(exp == 8'hCD));
    end else begin
      chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] held_sig;
    logic [7:0] exp;
    int         k;

    tick();
    tick();
    chk_reset0("reset");
    rst = 1'b0;
    tick();

    // Fault-free run
    fault0 = 1'b0;
    exp_q.push_back(model_sig(1'b0));
    pulse_start0();
    run0(1'b0, "good");
    chk("good_done", 32'(done0), 32'd1);
`ifdef BIST_RESP_CNT_EN
    chk("good_ones", 32'(ones0), 32'h668);
`endif
    held_sig = sig0;
    tick();
    tick();
    tick();
    chk("done_hold_sig", 32'(sig0), 32'(held_sig));
    chk("done_hold_pat", 32'(pat0), 32'd7);
    chk("done_hold_done", 32'(done0), 32'd1);

    // start in DONE: done/pass drop with the reseeding edge
    exp_q.push_back(model_sig(1'b0));
    pulse_start0();
    chk("restart_done", 32'(done0), 32'd0);
    chk("restart_pass", 32'(pass0), 32'd0);
    chk("restart_busy", 32'(busy0), 32'd1);
    chk("restart_sig",  32'(sig0),  32'd0);
    run0(1'b0, "rerun");

    // Stuck-at fault
    fault0 = 1'b1;
    exp_q.push_back(model_sig(1'b1));
    pulse_start0();
    run0(1'b0, "fault");
`ifdef BIST_RESP_CNT_EN
    chk("fault_ones", 32'(ones0), 32'h687);
`endif
    fault0 = 1'b0;

    // start pokes during APPLY and CAPTURE
    exp_q.push_back(model_sig(1'b0));
    pulse_start0();
    run0(1'b1, "poke");

    // Reset at pattern 4
    pulse_start0();
    for (int i = 0; i < 12; i++) tick();
    chk("mid_pat4", 32'(pat0), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset0("midrst");
    tick();
    chk("midrst_idle_busy", 32'(busy0), 32'd0);
    exp_q.push_back(model_sig(1'b0));
    pulse_start0();
    run0(1'b0, "after_rst");

    // NUM_PAT=1 instance
    exp_q.push_back(fold(8'h00, 3'b101));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    k = 0;
    while (!done1 && k < 50) begin
      tick();
      k++;
    end
    chk("np1_latency", 32'(k + 1), 32'd4);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("np1_sig",  32'(sig1),  32'(exp));
    chk("np1_pass", 32'(pass1), 32'd0);
    chk("np1_pat",  32'(pat1),  32'd0);

    // SETTLE=1 instance; wrong responses during APPLY must not leak in
    exp_q.push_back(model_sig(1'b0));
    resp2  = cut_resp(3'd0, 1'b0) ^ 3'($urandom_range(1, 7));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 100) begin
      if (k % 2 == 1) resp2 = cut_resp(pat2, 1'b0);
      else            resp2 = cut_resp(pat2, 1'b0) ^ 3'($urandom_range(1, 7));
      tick();
      k++;
    end
    chk("s1_latency", 32'(k + 1), 32'd17);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("s1_sig",  32'(sig2),  32'(exp));
    chk("s1_pass", 32'(pass2), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
